mbc1_ctrl: RTL and testbench
============================

MBC1_CTRL -- requirements
Module: mbc1_ctrl

Interface
REQ-001 Parameter ROM_ADDR_W, default 21, is the external ROM byte-address width; translated ROM addresses SHALL be truncated to these bits.
REQ-002 clk  input  1  single clock; all sequential logic SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 addr  input  16  CPU cartridge-space address.
REQ-005 data_w  input  8  CPU write data.
REQ-006 write_enable  input  1  one-cycle CPU write strobe.
REQ-007 read_enable  input  1  one-cycle CPU read strobe.
REQ-008 data_r  output  8  CPU read data, registered.
REQ-009 busy  output  1  external memory transaction in progress.
REQ-010 mem_req  output  1  external memory request, held until acknowledged.
REQ-011 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-012 mem_sel  output  1  0 = ROM, 1 = cart RAM.
REQ-013 mem_addr  output  21  translated byte address (RAM uses bits [14:0], upper bits 0).
REQ-014 mem_wdata  output  8  external write data.
REQ-015 mem_rdata  input  8  external read data; valid in the cycle mem_ack is high.
REQ-016 mem_ack  input  1  one-cycle acknowledge.

Function
REQ-017 Control-register writes (write_enable, addr < 0x8000) SHALL update at the next edge and SHALL NOT assert busy or mem_req.
- 0x0000-0x1FFF: ram_en <= (data_w[3:0] == 4'hA).
- 0x2000-0x3FFF: bank5 <= data_w[4:0].
- 0x4000-0x5FFF: bank2 <= data_w[1:0].
- 0x6000-0x7FFF: mode <= data_w[0].
REQ-018 Effective low bank: eff5 = (bank5 == 0) ? 1 : bank5; the zero fix-up SHALL apply to the 5-bit field only, so bank2 = 1 with bank5 = 0 selects bank 0x21.
REQ-019 ROM read 0x0000-0x3FFF: mem_addr = mode ? {bank2, 5'b0, addr[13:0]} : {7'b0, addr[13:0]}.
REQ-020 ROM read 0x4000-0x7FFF: mem_addr = {bank2, eff5, addr[13:0]}.
REQ-021 RAM access 0xA000-0xBFFF with ram_en = 1: mem_addr = {6'b0, mode ? bank2 : 2'b00, addr[12:0]}, mem_sel = 1.
REQ-022 RAM access with ram_en = 0, a read of any other unmapped address, and any write to 0x8000-0x9FFF or 0xC000-0xFFFF SHALL NOT issue mem_req.
- A read SHALL load data_r <= 8'hFF at the next edge.
- A write SHALL be ignored.
REQ-023 The FSM SHALL have two states, IDLE and WAIT.
- IDLE -> WAIT on an accepted ROM read, RAM read or RAM write.
- At that edge, mem_req, mem_we, mem_sel, mem_addr and mem_wdata SHALL be registered, and busy <= 1.
REQ-024 In WAIT, mem_req and all mem_* outputs SHALL stay stable until mem_ack is sampled high.
- At the edge that samples mem_ack high, the FSM SHALL return to IDLE and mem_req <= 0, busy <= 0.
- On a read, data_r <= mem_rdata at that same edge.
REQ-025 Latency: for a strobe sampled at edge N with mem_ack first high at edge N+k (k ≥ 1), data_r SHALL be valid and busy low after edge N+k; the minimum is one busy cycle.
REQ-026 All strobes (register writes included) SHALL be ignored while busy = 1.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 If read_enable and write_enable are both high, the write SHALL be performed and the read ignored.
REQ-029 ROM-range writes never reach memory; there SHALL be no ROM write path.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE and the following values:
- mem_req = 0, busy = 0, mem_we = 0, mem_sel = 0, mem_addr = 0, mem_wdata = 0.
- data_r = 8'hFF.
- ram_en = 0, bank5 = 0 (effective bank 1), bank2 = 0, mode = 0.
REQ-031 Reset during WAIT SHALL abandon the transaction; an ack arriving after reset SHALL be ignored per REQ-027.

Verification
REQ-032 The bench SHALL cover the following scenarios:
- Scenario 1: after reset, read 0x4000, ack 2 cycles after mem_req, mem_rdata 0x5A. Required: mem_addr 0x004000, mem_sel 0, data_r 0x5A, busy high for exactly 2 cycles.
- Scenario 2: write 0x2000 <= 0x1F, 0x4000 <= 0x03, then read 0x7FFF. Required: mem_addr 0x1FFFFF.
- Scenario 3: write 0x4000 <= 0x01, 0x2000 <= 0x00, then read 0x4000. Required: mem_addr 0x084000. Then write 0x6000 <= 0x01 and read 0x0000. Required: mem_addr 0x080000.
- Scenario 4: read 0xA000 with RAM disabled. Required: data_r 0xFF, no mem_req. Then write 0x0000 <= 0x0A and write 0xA005 <= 0x77. Required: mem_we 1, mem_sel 1, mem_addr 0x000005, mem_wdata 0x77. Then write 0x0000 <= 0x0B and repeat the write. Required: no mem_req.
- Scenario 5: read 0x4000 with ack withheld, then strobe read 0x0000 and write 0x2000 <= 0x05. Required: both ignored, mem_addr unchanged, bank5 unchanged.
- Scenario 6: reset_n low while mem_req is high. Required: mem_req 0 immediately, all REQ-030 values; a subsequent mem_ack has no effect.

Source files
------------

// File: rtl/mbc1_ctrl.sv
// MBC1 cartridge memory-bank controller.
// Decodes CPU cartridge-space strobes into bank-register updates or single
// external ROM/RAM transactions, and holds each transaction until acknowledged.
module mbc1_ctrl #(
    parameter int unsigned ROM_ADDR_W = 21
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           addr,
    input  logic [7:0]            data_w,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [7:0]            data_r,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [ROM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e                state_q, state_d;
    logic                  ram_en_q, ram_en_d;
    logic [4:0]            bank5_q, bank5_d;
    logic [1:0]            bank2_q, bank2_d;
    logic                  mode_q, mode_d;
    logic [7:0]            data_r_q, data_r_d;
    logic                  busy_q, busy_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_sel_q, mem_sel_d;
    logic [ROM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;

    logic [4:0]  eff5;
    logic [20:0] rom_addr;
    logic [20:0] ram_addr;
    logic        is_ctrl, is_ram;
    logic        wr_acc, rd_acc;
    logic        start_ram, start_rom;

    // Address translation and strobe qualification (strobes only count in IDLE;
    // a simultaneous write wins over a read).
    always_comb begin
        eff5      = (bank5_q == 5'd0) ? 5'd1 : bank5_q;
        if (addr[14])
            rom_addr = {bank2_q, eff5, addr[13:0]};
        else
            rom_addr = mode_q ? {bank2_q, 5'b0, addr[13:0]} : {7'b0, addr[13:0]};
        ram_addr  = {6'b0, (mode_q ? bank2_q : 2'b00), addr[12:0]};
        is_ctrl   = ~addr[15];
        is_ram    = (addr[15:13] == 3'b101);
        wr_acc    = (state_q == IDLE) && write_enable;
        rd_acc    = (state_q == IDLE) && read_enable && !write_enable;
        start_ram = is_ram && ram_en_q && (wr_acc || rd_acc);
        start_rom = rd_acc && is_ctrl;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ram || start_rom) state_d = WAIT;
            WAIT: if (mem_ack)                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for bank registers, read data and the memory request bundle.
    always_comb begin
        ram_en_d    = ram_en_q;
        bank5_d     = bank5_q;
        bank2_d     = bank2_q;
        mode_d      = mode_q;
        data_r_d    = data_r_q;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (start_ram || start_rom) begin
                    busy_d      = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = wr_acc;
                    mem_sel_d   = start_ram;
                    mem_addr_d  = start_ram ? ROM_ADDR_W'(ram_addr) : ROM_ADDR_W'(rom_addr);
                    mem_wdata_d = data_w;
                end else if (wr_acc && is_ctrl) begin
                    case (addr[14:13])
                        2'd0: ram_en_d = (data_w[3:0] == 4'hA);
                        2'd1: bank5_d  = data_w[4:0];
                        2'd2: bank2_d  = data_w[1:0];
                        default: mode_d = data_w[0];
                    endcase
                end else if (rd_acc) begin
                    data_r_d = '1;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    busy_d    = 1'b0;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) data_r_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_q    <= 1'b0;
            bank5_q     <= '0;
            bank2_q     <= '0;
            mode_q      <= 1'b0;
            data_r_q    <= '1;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            bank5_q     <= bank5_d;
            bank2_q     <= bank2_d;
            mode_q      <= mode_d;
            data_r_q    <= data_r_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign data_r    = data_r_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mbc1_ctrl.sv
// Directed bench for mbc1_ctrl: bank translation, RAM gating, busy timing,
// strobe blocking while busy, and asynchronous reset mid-transaction.
module tb_mbc1_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  data_w;
    logic        write_enable;
    logic        read_enable;
    logic [7:0]  data_r;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;
    int busy_cnt;

    mbc1_ctrl #(.ROM_ADDR_W(21)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .addr         (addr),
        .data_w       (data_w),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_r       (data_r),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; data_w = d; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        addr = a; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
    endtask

    // Single-cycle ack sampled at the next edge.
    task automatic ack(input logic [7:0] d);
        mem_ack = 1'b1; mem_rdata = d;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; addr = '0; data_w = '0;
        write_enable = 1'b0; read_enable = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_r", data_r, 8'hFF);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Scenario 1: read 0x4000, ack sampled two edges after the strobe edge
        cpu_read(16'h4000);
        busy_cnt = 0;
        if (busy) busy_cnt++;
        chk("s1_mem_req", mem_req, 1);
        chk("s1_mem_addr", mem_addr, 21'h004000);
        chk("s1_mem_sel", mem_sel, 0);
        chk("s1_mem_we", mem_we, 0);
        tick();
        if (busy) busy_cnt++;
        ack(8'h5A);
        if (busy) busy_cnt++;
        chk("s1_busy_cycles", busy_cnt, 2);
        chk("s1_data_r", data_r, 8'h5A);
        chk("s1_req_low", mem_req, 0);

        // Scenario 2: max banks
        cpu_write(16'h2000, 8'h1F);
        chk("s2_regwr_busy", busy, 0);
        chk("s2_regwr_req", mem_req, 0);
        cpu_write(16'h4000, 8'h03);
        cpu_read(16'h7FFF);
        chk("s2_mem_addr", mem_addr, 21'h1FFFFF);
        ack(8'h33);
        chk("s2_data_r", data_r, 8'h33);
        chk("s2_busy", busy, 0);

        // Scenario 3: bank5 zero fix-up, then mode 1 on low window
        cpu_write(16'h4000, 8'h01);
        cpu_write(16'h2000, 8'h00);
        cpu_read(16'h4000);
        chk("s3_mem_addr_hi", mem_addr, 21'h084000);
        ack(8'h01);
        cpu_write(16'h6000, 8'h01);
        cpu_read(16'h0000);
        chk("s3_mem_addr_lo", mem_addr, 21'h080000);
        ack(8'h02);

        // RAM read in mode 1 uses bank2 as RAM bank
        cpu_write(16'h0000, 8'h0A);
        cpu_read(16'hB123);
        chk("ram_m1_addr", mem_addr, 21'h003123);
        chk("ram_m1_sel", mem_sel, 1);
        ack(8'h9C);
        chk("ram_m1_data", data_r, 8'h9C);
        cpu_write(16'h0000, 8'h00);
        cpu_write(16'h6000, 8'h00);

        // Scenario 4: RAM gating
        cpu_read(16'hA000);
        chk("s4_dis_req", mem_req, 0);
        chk("s4_dis_busy", busy, 0);
        chk("s4_dis_data", data_r, 8'hFF);
        cpu_write(16'h0000, 8'h0A);
        cpu_write(16'hA005, 8'h77);
        chk("s4_req", mem_req, 1);
        chk("s4_we", mem_we, 1);
        chk("s4_sel", mem_sel, 1);
        chk("s4_addr", mem_addr, 21'h000005);
        chk("s4_wdata", mem_wdata, 8'h77);
        ack(8'h44);
        chk("s4_wr_data_r", data_r, 8'hFF);
        chk("s4_wr_busy", busy, 0);
        cpu_write(16'h0000, 8'h0B);
        cpu_write(16'hA005, 8'h77);
        chk("s4_dis_wr_req", mem_req, 0);
        cpu_write(16'hC000, 8'h12);
        chk("unmapped_wr_req", mem_req, 0);
        cpu_read(16'h9000);
        chk("unmapped_rd_req", mem_req, 0);

        // Scenario 5: strobes ignored while busy (bank2=1, bank5=0)
        cpu_read(16'h4000);
        chk("s5_addr0", mem_addr, 21'h084000);
        cpu_read(16'h0000);
        chk("s5_addr1", mem_addr, 21'h084000);
        chk("s5_busy", busy, 1);
        cpu_write(16'h2000, 8'h05);
        chk("s5_addr2", mem_addr, 21'h084000);
        chk("s5_we", mem_we, 0);
        ack(8'h66);
        chk("s5_data_r", data_r, 8'h66);
        cpu_read(16'h4000);
        chk("s5_bank5_kept", mem_addr, 21'h084000);
        ack(8'h67);

        // Ack in IDLE ignored
        ack(8'hAB);
        chk("idle_ack_data", data_r, 8'h67);
        chk("idle_ack_busy", busy, 0);

        // Simultaneous read/write: write wins
        addr = 16'h2000; data_w = 8'h03; write_enable = 1'b1; read_enable = 1'b1;
        tick();
        write_enable = 1'b0; read_enable = 1'b0;
        chk("rw_both_req", mem_req, 0);
        cpu_read(16'h4000);
        chk("rw_both_bank", mem_addr, 21'h08C000);
        ack(8'h10);

        // Scenario 6: reset during WAIT
        cpu_write(16'h0000, 8'h0A);
        cpu_read(16'hA001);
        chk("s6_req_before", mem_req, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("s6_req", mem_req, 0);
        chk("s6_busy", busy, 0);
        chk("s6_we", mem_we, 0);
        chk("s6_sel", mem_sel, 0);
        chk("s6_addr", mem_addr, 0);
        chk("s6_wdata", mem_wdata, 0);
        chk("s6_data_r", data_r, 8'hFF);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ack(8'h12);
        chk("s6_late_ack_data", data_r, 8'hFF);
        chk("s6_late_ack_busy", busy, 0);
        cpu_read(16'hA000);
        chk("s6_ram_en_reset", mem_req, 0);
        cpu_read(16'h4000);
        chk("s6_bank_reset", mem_addr, 21'h004000);
        ack(8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
